// File: rtl/data_mem_responder_if.sv
// ---------------------------------------------------------------------------
// data_mem_responder_if
// Bus bundle between a pipeline's load/store stage (master) and the data
// memory responder (slave).
//   req   : access request, held high by the master until ack
//   we    : 1 = write, 0 = read (qualified by req)
//   addr  : 32-bit byte address
//   wdata : 32-bit store data
//   be    : byte enables, be[i] selects wdata[8i+7:8i]
//           (exists only when DATA_MEM_BYTE_EN_EN is defined)
//   rdata : load data, valid with ack and held until the next ack
//   ack   : one-cycle completion pulse
//   err   : misaligned-access flag, asserted together with ack
//   stall : pipeline freeze, req AND NOT ack
// ---------------------------------------------------------------------------
interface data_mem_responder_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
`ifdef DATA_MEM_BYTE_EN_EN
  logic [3:0]  be;
`endif
  logic [31:0] rdata;
  logic        ack;
  logic        err;
  logic        stall;

`ifdef DATA_MEM_BYTE_EN_EN
  modport master (output req, we, addr, wdata, be,
                  input  rdata, ack, err, stall);
  modport slave  (input  req, we, addr, wdata, be,
                  output rdata, ack, err, stall);
`else
  modport master (output req, we, addr, wdata,
                  input  rdata, ack, err, stall);
  modport slave  (input  req, we, addr, wdata,
                  output rdata, ack, err, stall);
`endif
endinterface

// File: rtl/data_mem_responder.sv
// ---------------------------------------------------------------------------
// data_mem_responder
// Word-organised data memory with a fixed, parameterisable access latency.
// An access is accepted in IDLE, waits WAIT_CYCLES cycles in WAIT, then
// completes with a one-cycle ack in RESP. Misaligned accesses complete
// with err=1, rdata=0 and no write.
//
// Ports:
//   clka : clock, rising edge
//   rst  : synchronous active-high reset (storage is not cleared)
//   bus  : data_mem_responder_if.slave (req/we/addr/wdata[/be] in,
//          rdata/ack/err/stall out)
//
// Parameters:
//   DEPTH_LOG2  : log2 of the word count of storage
//   WAIT_CYCLES : extra wait cycles per access, 0..15
//
// Optional feature macro: DATA_MEM_BYTE_EN_EN
//   defined   -> bus.be exists and writes update only enabled bytes
//   undefined -> every write updates the full 32-bit word
// ---------------------------------------------------------------------------
module data_mem_responder #(
  parameter int DEPTH_LOG2  = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                 clka,
  input  logic                 rst,
  data_mem_responder_if.slave  bus
);

  localparam int         DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [31:0]             rdata_q;

  // Access attributes captured at acceptance; only these govern the access.
  logic                    we_q;
  logic [DEPTH_LOG2-1:0]   idx_q;
  logic                    mis_q;
  logic [31:0]             wdata_q;
`ifdef DATA_MEM_BYTE_EN_EN
  logic [3:0]              be_q;
`endif

  logic [31:0]             mem [DEPTH];

  logic                    accept;
  logic                    enter_resp;
  logic                    ack_w;
  logic                    acc_we;
  logic                    acc_mis;
  logic [DEPTH_LOG2-1:0]   acc_idx;

  // Address bits above the word index are ignored (accesses wrap).
  wire unused_addr_hi = &{1'b0, bus.addr[31:DEPTH_LOG2+2]};

  assign accept = (state_q == IDLE) && bus.req;
  assign ack_w  = (state_q == RESP);

  // With WAIT_CYCLES=0 RESP is entered straight from IDLE, before the
  // latched copies exist, so the read path looks at the live bus then.
  assign acc_we  = (state_q == IDLE) ? bus.we                       : we_q;
  assign acc_mis = (state_q == IDLE) ? (bus.addr[1:0] != 2'b00)     : mis_q;
  assign acc_idx = (state_q == IDLE) ? bus.addr[DEPTH_LOG2+1:2]     : idx_q;

  assign enter_resp = (state_d == RESP) && (state_q != RESP);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (bus.req) begin
          if (WAIT_CYCLES > 0) begin
            state_d = WAIT;
            cnt_d   = WAIT_LOAD;
          end else begin
            state_d = RESP;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clka) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      // Writes leave rdata untouched; misaligned accesses clear it.
      if (enter_resp) begin
        if (acc_mis) begin
          rdata_q <= '0;
        end else if (!acc_we) begin
          rdata_q <= mem[acc_idx];
        end
      end
    end
  end

  always_ff @(posedge clka) begin
    if (accept) begin
      we_q    <= bus.we;
      idx_q   <= bus.addr[DEPTH_LOG2+1:2];
      mis_q   <= (bus.addr[1:0] != 2'b00);
      wdata_q <= bus.wdata;
`ifdef DATA_MEM_BYTE_EN_EN
      be_q    <= bus.be;
`endif
    end
  end

  // Commit happens at the edge closing RESP, so a reset landing on that
  // edge still aborts the write.
  always_ff @(posedge clka) begin
    if (!rst && (state_q == RESP) && we_q && !mis_q) begin
`ifdef DATA_MEM_BYTE_EN_EN
      for (int i = 0; i < 4; i++) begin
        if (be_q[i]) begin
          mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
        end
      end
`else
      mem[idx_q] <= wdata_q;
`endif
    end
  end

  assign bus.rdata = rdata_q;
  assign bus.ack   = ack_w;
  assign bus.err   = ack_w && mis_q;
  assign bus.stall = bus.req && !ack_w;

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 8, meaning log2 of the word count of internal storage (256 words).
REQ-002 SHALL have parameter WAIT_CYCLES, default 2, meaning extra wait cycles per access; legal range 0..15.
REQ-003 SHALL have port clka, input, 1 bit: the single clock; all logic samples on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port req, input, 1 bit: initiator access request, held high until ack.
REQ-006 SHALL have port we, input, 1 bit: 1 means write, 0 means read; qualified by req.
REQ-007 SHALL have port addr, input, 32 bits: byte address from the pipeline's ALU result.
REQ-008 SHALL have port wdata, input, 32 bits: store data.
REQ-009 SHALL have port be, input, 4 bits: byte enables, be[i] selects wdata[8i+7:8i]; present only under REQ-030.
REQ-010 SHALL have port rdata, output, 32 bits: load data, valid while ack is high and held until the next ack.
REQ-011 SHALL have port ack, output, 1 bit: one-cycle completion pulse.
REQ-012 SHALL have port err, output, 1 bit: misaligned-access flag, asserted together with ack.
REQ-013 SHALL have port stall, output, 1 bit: pipeline freeze, combinational req AND NOT ack.

Function
REQ-014 SHALL implement an FSM with states IDLE, WAIT and RESP.
REQ-015 IDLE with req=1 at a rising edge SHALL latch we, addr, wdata and be, then go to WAIT if WAIT_CYCLES>0, else to RESP.
REQ-016 WAIT SHALL load a 4-bit counter with WAIT_CYCLES-1 on entry, decrement it each cycle, and go to RESP on the cycle the counter is 0.
REQ-017 RESP SHALL drive ack=1 for exactly one cycle and then return to IDLE unconditionally.
REQ-018 Latency SHALL be: req sampled at edge N gives ack high during cycle N+1+WAIT_CYCLES.
REQ-019 The earliest next acceptance SHALL be the edge after the ack cycle; a req still high then is a new request.
REQ-020 The word index SHALL be addr[DEPTH_LOG2+1:2]; higher address bits are ignored, so out-of-range addresses wrap modulo depth.
REQ-021 A write SHALL commit to storage at the edge ending the RESP cycle, using the latched data.
REQ-022 For a write, rdata SHALL keep its previous value.
REQ-023 For a read, rdata SHALL be updated at the edge entering RESP with the word at the latched index.
REQ-024 A read issued after a completed write to the same index SHALL return the written data.
REQ-025 addr[1:0] not equal to 00 SHALL set err=1 in the RESP cycle, suppress any write, and set rdata to 0.
REQ-026 req or input changes while in WAIT or RESP SHALL be ignored; the latched values govern the access.

Reset
REQ-027 With rst=1 at an edge, the block SHALL go to IDLE, with ack=0, err=0, rdata=0 and counter=0.
REQ-028 Reset SHALL NOT clear storage contents.
REQ-029 Reset in WAIT or RESP SHALL abort the access with no write and no ack; rst has priority over every other event.

Configuration
REQ-030 With macro DATA_MEM_BYTE_EN_EN defined, port be SHALL exist and a write SHALL update only the enabled bytes; be=0000 is a legal write that changes nothing but still acks.
REQ-031 Without DATA_MEM_BYTE_EN_EN, port be SHALL be absent and every write SHALL update the full 32-bit word.

Verification
REQ-032 Reset, then write addr=0x00000010, wdata=0xDEADBEEF, WAIT_CYCLES=2 -> ack high exactly 3 cycles after acceptance and stall high for the 3 cycles before it; then a read of 0x10 returns 0xDEADBEEF with err=0.
REQ-033 Read of addr=0x00000013 -> err=1 and rdata=0x00000000 in the ack cycle; a follow-up read of 0x10 still returns 0xDEADBEEF.
REQ-034 With DEPTH_LOG2=8, write 0xCAFEF00D to 0x00000400, then read 0x00000000 -> 0xCAFEF00D (wrap).
REQ-035 With DATA_MEM_BYTE_EN_EN, word holds 0x11223344; write be=0010, wdata=0x0000AA00 -> read returns 0x1122AA44.
REQ-036 Assert rst in the second WAIT cycle of a write of 0x55555555 to 0x20 -> no ack, state IDLE, and a later read of 0x20 returns the old value.
REQ-037 WAIT_CYCLES=0 with req held high for back-to-back reads -> ack on every second cycle, with stall low only in ack cycles.
